// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider:
// operand width, default tag width, FSM states and the divide-by-zero quotient.
package div_pkg;

  localparam int DIV_W = 16;
  localparam int TAG_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV0_QUOT = 16'hFFFF;

endpackage

// File: rtl/div_sub17.sv
// Combinational (W+1)-bit trial subtractor t - {0,divisor}, formed as t + ~divisor + 1
// so the bit cells match the generate/propagate cells of the lookahead adder.
module div_sub17
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W:0]   t,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0]   b_inv;
  logic [W+1:0] carry;
  logic [W:0]   gen;
  logic [W:0]   prop;

  assign b_inv    = ~{1'b0, divisor};
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi <= W; gi++) begin : g_cell
      assign gen[gi]      = t[gi] & b_inv[gi];
      assign prop[gi]     = t[gi] ^ b_inv[gi];
      assign carry[gi+1]  = gen[gi] | (prop[gi] & carry[gi]);
    end
    for (genvar gi = 0; gi < W; gi++) begin : g_sum
      assign diff[gi] = prop[gi] ^ carry[gi];
    end
  endgenerate

  // No carry out of the top bit means t < divisor.
  assign borrow = ~carry[W+1];

endmodule

// File: rtl/div16_seq.sv
// Sequential 16-bit unsigned restoring divider: one quotient bit per cycle,
// valid/ready issue and writeback handshakes, tag carried through.
module div16_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div0,
  output logic             busy
);

  state_t             state_reg;
  state_t             state_next;
  logic [4:0]         cnt_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   divisor_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic               div0_reg;

  logic               accept;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff;
  logic               borrow;

  assign accept = in_valid && (state_reg == IDLE);
  assign trial  = {rem_reg, q_reg[WIDTH-1]};

  div_sub17 #(.W(WIDTH)) u_sub (
    .t       (trial),
    .divisor (divisor_reg),
    .diff    (diff),
    .borrow  (borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Divide-by-zero also passes through one RUN cycle, giving its 1-cycle latency.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (div0_reg || cnt_reg == 5'(WIDTH - 1)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
  end

  // The partial remainder stays below the divisor, so 16 bits hold it between steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      rem_reg     <= '0;
      q_reg       <= '0;
      divisor_reg <= '0;
      tag_reg     <= '0;
      div0_reg    <= 1'b0;
    end else if (accept) begin
      tag_reg <= in_tag;
      cnt_reg <= '0;
      if (in_divisor == '0) begin
        div0_reg    <= 1'b1;
        divisor_reg <= '0;
        q_reg       <= DIV0_QUOT;
        rem_reg     <= in_dividend;
      end else begin
        div0_reg    <= 1'b0;
        divisor_reg <= in_divisor;
        q_reg       <= in_dividend;
        rem_reg     <= '0;
      end
    end else if (state_reg == RUN && !div0_reg) begin
      rem_reg <= borrow ? trial[WIDTH-1:0] : diff;
      q_reg   <= {q_reg[WIDTH-2:0], ~borrow};
      cnt_reg <= cnt_reg + 5'd1;
    end
  end

  assign out_quotient  = q_reg;
  assign out_remainder = rem_reg;
  assign out_tag       = tag_reg;
  assign out_div0      = div0_reg;

endmodule
